// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared types for the single-port memory arbiter
package arbiter_pkg;

    localparam int CMD_ADDR_BITS = 12;

    typedef enum logic [1:0] {
        PORT_FETCH = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_STORE = 2'd2
    } port_id_t;

    typedef struct packed {
        logic                     en;
        logic                     we;
        logic [CMD_ADDR_BITS-1:0] addr;
        logic [31:0]              wdata;
        logic [3:0]               strobe;
    } mem_cmd_t;

endpackage

// File: rtl/memory_port_arbiter_if.sv
// rtl/memory_port_arbiter_if.sv - requester and memory-side signal bundle
interface memory_port_arbiter_if #(
    parameter int ADDR_BITS = 12
);
    logic                 fetch_req_i;
    logic [ADDR_BITS-1:0] fetch_addr_i;
    logic                 fetch_inv_i;
    logic                 fetch_valid_o;
    logic [31:0]          fetch_data_o;
    logic                 fetch_busy_o;

    logic                 load_req_i;
    logic [ADDR_BITS-1:0] load_addr_i;
    logic                 load_inv_i;
    logic                 load_done_o;
    logic [31:0]          load_data_o;
    logic                 load_busy_o;

    logic                 store_req_i;
    logic [ADDR_BITS-1:0] store_addr_i;
    logic [31:0]          store_data_i;
    logic [3:0]           store_strobe_i;
    logic                 store_done_o;
    logic                 store_busy_o;

    logic                 mem_en_o;
    logic                 mem_we_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic [3:0]           mem_strobe_o;
    logic [31:0]          mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i, fetch_inv_i,
        output fetch_valid_o, fetch_data_o, fetch_busy_o,
        input  load_req_i, load_addr_i, load_inv_i,
        output load_done_o, load_data_o, load_busy_o,
        input  store_req_i, store_addr_i, store_data_i, store_strobe_i,
        output store_done_o, store_busy_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strobe_o,
        input  mem_rdata_i
    );

    modport master (
        output fetch_req_i, fetch_addr_i, fetch_inv_i,
        input  fetch_valid_o, fetch_data_o, fetch_busy_o,
        output load_req_i, load_addr_i, load_inv_i,
        input  load_done_o, load_data_o, load_busy_o,
        output store_req_i, store_addr_i, store_data_i, store_strobe_i,
        input  store_done_o, store_busy_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strobe_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/memory_port_arbiter_priority_picker.sv
// rtl/memory_port_arbiter_priority_picker.sv - store > load > fetch with starvation override
module priority_picker
    import arbiter_pkg::*;
(
    input  logic     fetch_v,
    input  logic     load_v,
    input  logic     store_v,
    input  logic     force_fetch,
    output logic     grant_v,
    output port_id_t grant_port
);
    always_comb begin
        grant_v    = fetch_v | load_v | store_v;
        grant_port = PORT_FETCH;
        if (force_fetch && fetch_v) begin
            grant_port = PORT_FETCH;
        end else if (store_v) begin
            grant_port = PORT_STORE;
        end else if (load_v) begin
            grant_port = PORT_LOAD;
        end
    end
endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one single-port memory bank between fetch, load and store
module memory_port_arbiter
    import arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    memory_port_arbiter_if.slave  bus
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
        $error("STARVE_LIMIT must be within 1..15");
    end
    if (ADDR_BITS != CMD_ADDR_BITS) begin : g_addr_chk
        $error("ADDR_BITS must match arbiter_pkg::CMD_ADDR_BITS");
    end

    logic                 f_pv, l_pv, s_pv;
    logic [ADDR_BITS-1:0] f_addr, l_addr, s_addr;
    logic [31:0]          s_data;
    logic [3:0]           s_strb;
    logic [3:0]           starve_cnt;
    mem_cmd_t             cmd_q;
    port_id_t             cmd_port, tag_port;
    logic                 cmd_live, tag_v;
    logic [31:0]          f_data_q, l_data_q;

    logic     grant_v, grant_f, grant_l, grant_s, grant_kill, cmd_kill;
    logic     f_acc, l_acc, s_acc;
    logic     f_hit, l_hit, s_hit;
    port_id_t grant_port;

    priority_picker u_pick (
        .fetch_v     (f_pv),
        .load_v      (l_pv),
        .store_v     (s_pv),
        .force_fetch (starve_cnt >= 4'(STARVE_LIMIT)),
        .grant_v     (grant_v),
        .grant_port  (grant_port)
    );

    assign grant_f = grant_v && grant_port == PORT_FETCH;
    assign grant_l = grant_v && grant_port == PORT_LOAD;
    assign grant_s = grant_v && grant_port == PORT_STORE;

    // Busy spans pending, command and response stages of the port.
    assign bus.fetch_busy_o = f_pv | (cmd_live && cmd_port == PORT_FETCH) | (tag_v && tag_port == PORT_FETCH);
    assign bus.load_busy_o  = l_pv | (cmd_live && cmd_port == PORT_LOAD)  | (tag_v && tag_port == PORT_LOAD);
    assign bus.store_busy_o = s_pv | (cmd_live && cmd_port == PORT_STORE) | (tag_v && tag_port == PORT_STORE);

    // An invalidate frees the port, so a same-cycle request replaces the old one.
    assign f_acc = bus.fetch_req_i && (!bus.fetch_busy_o || bus.fetch_inv_i);
    assign l_acc = bus.load_req_i  && (!bus.load_busy_o  || bus.load_inv_i);
    assign s_acc = bus.store_req_i && !bus.store_busy_o;

    assign grant_kill = (grant_port == PORT_FETCH && bus.fetch_inv_i) || (grant_port == PORT_LOAD && bus.load_inv_i);
    assign cmd_kill   = (cmd_port == PORT_FETCH && bus.fetch_inv_i) || (cmd_port == PORT_LOAD && bus.load_inv_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_pv <= 1'b0; f_addr <= '0;
            l_pv <= 1'b0; l_addr <= '0;
            s_pv <= 1'b0; s_addr <= '0; s_data <= '0; s_strb <= '0;
        end else begin
            if (f_acc) begin
                f_pv <= 1'b1; f_addr <= bus.fetch_addr_i;
            end else if (bus.fetch_inv_i || grant_f) begin
                f_pv <= 1'b0;
            end
            if (l_acc) begin
                l_pv <= 1'b1; l_addr <= bus.load_addr_i;
            end else if (bus.load_inv_i || grant_l) begin
                l_pv <= 1'b0;
            end
            if (s_acc) begin
                s_pv <= 1'b1; s_addr <= bus.store_addr_i;
                s_data <= bus.store_data_i; s_strb <= bus.store_strobe_i;
            end else if (grant_s) begin
                s_pv <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (grant_f || bus.fetch_inv_i) begin
            starve_cnt <= '0;
        end else if (f_pv && grant_v && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A killed grant still reads memory; only the response is suppressed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q    <= '0;
            cmd_port <= PORT_FETCH;
            cmd_live <= 1'b0;
            tag_v    <= 1'b0;
            tag_port <= PORT_FETCH;
        end else begin
            cmd_q.en     <= grant_v;
            cmd_q.we     <= grant_s;
            cmd_q.addr   <= grant_s ? s_addr : grant_l ? l_addr : f_addr;
            cmd_q.wdata  <= s_data;
            cmd_q.strobe <= grant_s ? s_strb : 4'b0000;
            cmd_port     <= grant_port;
            cmd_live     <= grant_v && !grant_kill;
            tag_v        <= cmd_live && !cmd_kill;
            tag_port     <= cmd_port;
        end
    end

    assign f_hit = tag_v && tag_port == PORT_FETCH;
    assign l_hit = tag_v && tag_port == PORT_LOAD;
    assign s_hit = tag_v && tag_port == PORT_STORE;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_data_q <= '0;
            l_data_q <= '0;
        end else begin
            if (f_hit) f_data_q <= bus.mem_rdata_i;
            if (l_hit) l_data_q <= bus.mem_rdata_i;
        end
    end

    assign bus.fetch_valid_o = f_hit;
    assign bus.load_done_o   = l_hit;
    assign bus.store_done_o  = s_hit;
    assign bus.fetch_data_o  = f_hit ? bus.mem_rdata_i : f_data_q;
    assign bus.load_data_o   = l_hit ? bus.mem_rdata_i : l_data_q;

    assign bus.mem_en_o     = cmd_q.en;
    assign bus.mem_we_o     = cmd_q.we;
    assign bus.mem_addr_o   = cmd_q.addr;
    assign bus.mem_wdata_o  = cmd_q.wdata;
    assign bus.mem_strobe_o = cmd_q.strobe;

    a_fetch_req_busy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(bus.fetch_req_i && bus.fetch_busy_o && !bus.fetch_inv_i))
        else $warning("fetch request while busy ignored");
    a_load_req_busy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(bus.load_req_i && bus.load_busy_o && !bus.load_inv_i))
        else $warning("load request while busy ignored");
    a_store_req_busy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(bus.store_req_i && bus.store_busy_o))
        else $warning("store request while busy ignored");
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;
    import arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    memory_port_arbiter_if #(.ADDR_BITS(12)) bus ();

    memory_port_arbiter #(.ADDR_BITS(12), .STARVE_LIMIT(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Single-port synchronous memory model: read data valid the cycle after mem_en.
    logic [31:0] mem [0:4095];
    logic [31:0] rdata_q = 32'h0;
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_strobe_o[b]) mem[bus.mem_addr_o][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
            end else begin
                rdata_q <= mem[bus.mem_addr_o];
            end
        end
    end
    assign bus.mem_rdata_i = rdata_q;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.fetch_req_i = 0; bus.fetch_inv_i = 0;
        bus.load_req_i = 0;  bus.load_inv_i = 0;
        bus.store_req_i = 0;
    endtask

    task automatic test_reset;
        step; step;
        checks++;
        if ({bus.fetch_busy_o, bus.load_busy_o, bus.store_busy_o} !== 3'b000) begin
            errors++; $display("FAIL reset_busy got %b exp 000", {bus.fetch_busy_o, bus.load_busy_o, bus.store_busy_o});
        end
        checks++;
        if ({bus.fetch_valid_o, bus.load_done_o, bus.store_done_o, bus.mem_en_o, bus.mem_we_o} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses got %b exp 00000", {bus.fetch_valid_o, bus.load_done_o, bus.store_done_o, bus.mem_en_o, bus.mem_we_o});
        end
        checks++;
        if ({bus.fetch_data_o, bus.load_data_o} !== 64'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {bus.fetch_data_o, bus.load_data_o});
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_lone_fetch;
        bus.fetch_req_i = 1; bus.fetch_addr_i = 12'h010;
        step;
        bus.fetch_req_i = 0;
        checks++;
        if ({bus.fetch_busy_o, bus.fetch_valid_o, bus.mem_en_o} !== 3'b100) begin
            errors++; $display("FAIL fetch_n1 got %b exp 100", {bus.fetch_busy_o, bus.fetch_valid_o, bus.mem_en_o});
        end
        step;
        checks++;
        if ({bus.fetch_busy_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o} !== {3'b110, 12'h010}) begin
            errors++; $display("FAIL fetch_cmd got %h exp %h", {bus.fetch_busy_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o}, {3'b110, 12'h010});
        end
        step;
        checks++;
        if ({bus.fetch_busy_o, bus.fetch_valid_o, bus.fetch_data_o} !== {2'b11, 32'h00000013}) begin
            errors++; $display("FAIL fetch_valid got %h exp %h", {bus.fetch_busy_o, bus.fetch_valid_o, bus.fetch_data_o}, {2'b11, 32'h00000013});
        end
        step;
        checks++;
        if ({bus.fetch_busy_o, bus.fetch_valid_o, bus.fetch_data_o} !== {2'b00, 32'h00000013}) begin
            errors++; $display("FAIL fetch_after got %h exp %h", {bus.fetch_busy_o, bus.fetch_valid_o, bus.fetch_data_o}, {2'b00, 32'h00000013});
        end
    endtask

    task automatic test_store_load_order;
        bus.store_req_i = 1; bus.store_addr_i = 12'h020; bus.store_data_i = 32'hDEADBEEF; bus.store_strobe_i = 4'b0011;
        bus.load_req_i = 1;  bus.load_addr_i = 12'h020;
        step;
        clear_inputs();
        checks++;
        if ({bus.store_busy_o, bus.load_busy_o, bus.mem_en_o} !== 3'b110) begin
            errors++; $display("FAIL order_pend got %b exp 110", {bus.store_busy_o, bus.load_busy_o, bus.mem_en_o});
        end
        step;
        checks++;
        if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_strobe_o, bus.mem_wdata_o} !== {2'b11, 12'h020, 4'b0011, 32'hDEADBEEF}) begin
            errors++; $display("FAIL order_store_cmd got %h exp %h", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_strobe_o, bus.mem_wdata_o}, {2'b11, 12'h020, 4'b0011, 32'hDEADBEEF});
        end
        step;
        checks++;
        if ({bus.store_done_o, bus.load_done_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o} !== {4'b1010, 12'h020}) begin
            errors++; $display("FAIL order_store_done got %h exp %h", {bus.store_done_o, bus.load_done_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o}, {4'b1010, 12'h020});
        end
        step;
        checks++;
        if ({bus.store_done_o, bus.load_done_o, bus.load_data_o} !== {2'b01, 32'h1122BEEF}) begin
            errors++; $display("FAIL order_load_done got %h exp %h", {bus.store_done_o, bus.load_done_o, bus.load_data_o}, {2'b01, 32'h1122BEEF});
        end
        step;
        checks++;
        if ({bus.load_done_o, bus.load_busy_o, bus.store_busy_o, bus.load_data_o} !== {3'b000, 32'h1122BEEF}) begin
            errors++; $display("FAIL order_hold got %h exp %h", {bus.load_done_o, bus.load_busy_o, bus.store_busy_o, bus.load_data_o}, {3'b000, 32'h1122BEEF});
        end
    endtask

    task automatic test_starvation;
        bus.fetch_req_i = 1; bus.fetch_addr_i = 12'h080;
        bus.load_req_i = 1;  bus.load_addr_i = 12'h070;
        step;
        bus.fetch_req_i = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.load_req_i = 1; bus.load_inv_i = 1;
            checks++;
            if ({bus.fetch_valid_o, bus.load_done_o, bus.fetch_busy_o} !== 3'b001) begin
                errors++; $display("FAIL starve_wait%0d got %b exp 001", i, {bus.fetch_valid_o, bus.load_done_o, bus.fetch_busy_o});
            end
            if (i >= 2) begin
                checks++;
                if ({bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 12'h070}) begin
                    errors++; $display("FAIL starve_load_cmd%0d got %h exp %h", i, {bus.mem_en_o, bus.mem_addr_o}, {1'b1, 12'h070});
                end
            end
            step;
        end
        clear_inputs();
        checks++;
        if (dut.starve_cnt !== 4'd4) begin
            errors++; $display("FAIL starve_cnt_limit got %0d exp 4", dut.starve_cnt);
        end
        step;
        checks++;
        if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b10, 12'h080}) begin
            errors++; $display("FAIL starve_fetch_cmd got %h exp %h", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o}, {2'b10, 12'h080});
        end
        step;
        checks++;
        if ({bus.fetch_valid_o, bus.load_done_o, bus.fetch_data_o, dut.starve_cnt} !== {2'b10, 32'h88888888, 4'd0}) begin
            errors++; $display("FAIL starve_fetch_valid got %h exp %h", {bus.fetch_valid_o, bus.load_done_o, bus.fetch_data_o, dut.starve_cnt}, {2'b10, 32'h88888888, 4'd0});
        end
        step;
        checks++;
        if ({bus.load_done_o, bus.load_data_o} !== {1'b1, 32'h77777777}) begin
            errors++; $display("FAIL starve_last_load got %h exp %h", {bus.load_done_o, bus.load_data_o}, {1'b1, 32'h77777777});
        end
        step;
    endtask

    task automatic test_invalidate;
        bus.fetch_req_i = 1; bus.fetch_addr_i = 12'h050;
        step;
        bus.fetch_req_i = 0;
        step;
        checks++;
        if ({bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 12'h050}) begin
            errors++; $display("FAIL inv_cmd got %h exp %h", {bus.mem_en_o, bus.mem_addr_o}, {1'b1, 12'h050});
        end
        bus.fetch_inv_i = 1;
        step;
        bus.fetch_inv_i = 0;
        checks++;
        if ({bus.fetch_valid_o, bus.fetch_busy_o, bus.fetch_data_o} !== {2'b00, 32'h88888888}) begin
            errors++; $display("FAIL inv_killed got %h exp %h", {bus.fetch_valid_o, bus.fetch_busy_o, bus.fetch_data_o}, {2'b00, 32'h88888888});
        end
        bus.fetch_req_i = 1; bus.fetch_addr_i = 12'h060;
        step;
        bus.fetch_req_i = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.fetch_valid_o !== 1'b0) begin
                errors++; $display("FAIL inv_early_valid%0d got %b exp 0", i, bus.fetch_valid_o);
            end
            step;
        end
        checks++;
        if ({bus.fetch_valid_o, bus.fetch_data_o} !== {1'b1, 32'h00600093}) begin
            errors++; $display("FAIL inv_refetch got %h exp %h", {bus.fetch_valid_o, bus.fetch_data_o}, {1'b1, 32'h00600093});
        end
        step;
    endtask

    task automatic test_reset_midflight;
        int pulses = 0;
        bus.store_req_i = 1; bus.store_addr_i = 12'h090; bus.store_data_i = 32'h12345678; bus.store_strobe_i = 4'hF;
        bus.load_req_i = 1;  bus.load_addr_i = 12'h0A0;
        bus.fetch_req_i = 1; bus.fetch_addr_i = 12'h0B0;
        step;
        clear_inputs();
        checks++;
        if ({bus.fetch_busy_o, bus.load_busy_o, bus.store_busy_o} !== 3'b111) begin
            errors++; $display("FAIL rst_pending got %b exp 111", {bus.fetch_busy_o, bus.load_busy_o, bus.store_busy_o});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.fetch_busy_o, bus.load_busy_o, bus.store_busy_o, bus.mem_en_o} !== 4'b0000) begin
            errors++; $display("FAIL rst_async got %b exp 0000", {bus.fetch_busy_o, bus.load_busy_o, bus.store_busy_o, bus.mem_en_o});
        end
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            pulses += int'(bus.fetch_valid_o) + int'(bus.load_done_o) + int'(bus.store_done_o) + int'(bus.mem_en_o);
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL rst_no_pulses got %0d exp 0", pulses);
        end
        checks++;
        if (mem[12'h090] !== 32'h0) begin
            errors++; $display("FAIL rst_no_store got %h exp 0", mem[12'h090]);
        end
    endtask

    task automatic test_busy_violation;
        int dones = 0;
        logic [31:0] seen = 32'h0;
        bus.load_req_i = 1; bus.load_addr_i = 12'h030;
        step;
        checks++;
        if (bus.load_busy_o !== 1'b1) begin
            errors++; $display("FAIL viol_busy got %b exp 1", bus.load_busy_o);
        end
        bus.load_addr_i = 12'h040;
        step;
        bus.load_req_i = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.load_done_o) begin
                dones++;
                seen = bus.load_data_o;
            end
            step;
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL viol_done_count got %0d exp 1", dones);
        end
        checks++;
        if (seen !== 32'hA5A50030) begin
            errors++; $display("FAIL viol_data got %h exp A5A50030", seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        mem[12'h010] = 32'h00000013;
        mem[12'h020] = 32'h11223344;
        mem[12'h030] = 32'hA5A50030;
        mem[12'h040] = 32'hA5A50040;
        mem[12'h050] = 32'h00500013;
        mem[12'h060] = 32'h00600093;
        mem[12'h070] = 32'h77777777;
        mem[12'h080] = 32'h88888888;
        clear_inputs();
        bus.fetch_addr_i = '0; bus.load_addr_i = '0; bus.store_addr_i = '0;
        bus.store_data_i = '0; bus.store_strobe_i = '0;

        test_reset();
        test_lone_fetch();
        test_store_load_order();
        test_starvation();
        test_invalidate();
        test_reset_midflight();
        test_busy_violation();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
